// File: rtl/stb_port_arbiter.sv
// stb_port_arbiter: arbitrates one shared port between an SPI and an I2C controller.
// Break-before-make: every hand-over passes through a GUARD-cycle setup or release phase.
// Optional watchdog (define STB_ARB_TIMEOUT_EN) forces a release after TIMEOUT grant cycles.
module stb_port_arbiter #(
    parameter int unsigned GUARD   = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       stb_en,
    input  logic       spi_req,
    input  logic       spi_busy,
    input  logic [2:0] spi_cs,
    input  logic       spi_pol,
    input  logic       i2c_req,
    input  logic       i2c_busy,
    input  logic [2:0] i2c_sel,
    output logic       spi_gnt,
    output logic       i2c_gnt,
    output logic [5:0] ctrl,
    output logic       timeout_err,
    input  logic       err_clr
);

    typedef enum logic [2:0] {
        StDtb, StIdle, StSetupSpi, StSetupI2c, StGntSpi, StGntI2c, StRelease
    } state_e;

    localparam logic [7:0] GuardLoad = 8'(GUARD - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pol_q, pol_d;
    logic [2:0] cs_q, cs_d;
    logic [2:0] sel_q, sel_d;
    logic       last_spi_q, last_spi_d;  // 1: SPI was granted last, so I2C wins the next tie
    logic [5:0] ctrl_q, ctrl_d;
    logic       pick_spi, pick_i2c;
    logic       timeout_hit;

`ifdef STB_ARB_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        err_q, err_d;

    assign timeout_hit = ((state_q == StGntSpi) || (state_q == StGntI2c)) &&
                         (wd_q == 16'(TIMEOUT - 1));

    // Watchdog counts consecutive grant cycles; flag set has priority over clear.
    always_comb begin
        wd_d  = 16'd0;
        err_d = err_q;
        if (((state_q == StGntSpi) || (state_q == StGntI2c)) && (state_d == state_q)) begin
            wd_d = wd_q + 16'd1;
        end
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Watchdog state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q  <= 16'd0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    logic        unused_err_clr;
    logic [15:0] unused_timeout;

    assign unused_err_clr = err_clr;
    assign unused_timeout = 16'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // Next-state, guard counter, latched selects and the next control word.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pol_d      = pol_q;
        cs_d       = cs_q;
        sel_d      = sel_q;
        last_spi_d = last_spi_q;
        pick_spi   = spi_req && (!i2c_req || !last_spi_q);
        pick_i2c   = i2c_req && !pick_spi;

        case (state_q)
            StDtb: begin
                if (stb_en) state_d = StIdle;
            end
            StIdle: begin
                if (pick_spi) begin
                    state_d    = StSetupSpi;
                    cnt_d      = GuardLoad;
                    cs_d       = spi_cs;
                    pol_d      = spi_pol;
                    last_spi_d = 1'b1;
                end else if (pick_i2c) begin
                    state_d    = StSetupI2c;
                    cnt_d      = GuardLoad;
                    sel_d      = i2c_sel;
                    last_spi_d = 1'b0;
                end
            end
            StSetupSpi: begin
                if (cnt_q == 8'd0) state_d = StGntSpi;
                else               cnt_d   = cnt_q - 8'd1;
            end
            StSetupI2c: begin
                if (cnt_q == 8'd0) state_d = StGntI2c;
                else               cnt_d   = cnt_q - 8'd1;
            end
            StGntSpi: begin
                if ((!spi_req && !spi_busy) || timeout_hit) begin
                    state_d = StRelease;
                    cnt_d   = GuardLoad;
                end
            end
            StGntI2c: begin
                if ((!i2c_req && !i2c_busy) || timeout_hit) begin
                    state_d = StRelease;
                    cnt_d   = GuardLoad;
                end
            end
            StRelease: begin
                if (cnt_q == 8'd0) state_d = StIdle;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = StDtb;
        endcase

        // Leaving STB mode overrides everything.
        if (!stb_en) begin
            state_d = StDtb;
            cnt_d   = 8'd0;
        end

        // ctrl follows the next state so it switches together with the state.
        case (state_d)
            StIdle, StRelease:      ctrl_d = 6'h20;
            StSetupSpi, StGntSpi:   ctrl_d = {1'b1, 1'b1, pol_d, cs_d};
            StSetupI2c, StGntI2c:   ctrl_d = {1'b1, 1'b0, 1'b0, sel_d};
            default:                ctrl_d = 6'h00;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StDtb;
            cnt_q      <= 8'd0;
            pol_q      <= 1'b0;
            cs_q       <= 3'd0;
            sel_q      <= 3'd0;
            last_spi_q <= 1'b0;
            ctrl_q     <= 6'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pol_q      <= pol_d;
            cs_q       <= cs_d;
            sel_q      <= sel_d;
            last_spi_q <= last_spi_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign spi_gnt = (state_q == StGntSpi);
    assign i2c_gnt = (state_q == StGntI2c);
    assign ctrl    = ctrl_q;

endmodule

// File: tb/tb_stb_port_arbiter.sv
// Directed bench for stb_port_arbiter with GUARD=4, TIMEOUT=16.
// Watchdog expectations follow STB_ARB_TIMEOUT_EN.
module tb_stb_port_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       stb_en;
    logic       spi_req, spi_busy, spi_pol;
    logic [2:0] spi_cs;
    logic       i2c_req, i2c_busy;
    logic [2:0] i2c_sel;
    logic       spi_gnt, i2c_gnt, timeout_err, err_clr;
    logic [5:0] ctrl;

    int n_cmp = 0;
    int n_err = 0;

    stb_port_arbiter #(.GUARD(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stb_en      (stb_en),
        .spi_req     (spi_req),
        .spi_busy    (spi_busy),
        .spi_cs      (spi_cs),
        .spi_pol     (spi_pol),
        .i2c_req     (i2c_req),
        .i2c_busy    (i2c_busy),
        .i2c_sel     (i2c_sel),
        .spi_gnt     (spi_gnt),
        .i2c_gnt     (i2c_gnt),
        .ctrl        (ctrl),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stb_en   = 1'b1;
        spi_req  = 1'b0;
        spi_busy = 1'b0;
        spi_pol  = 1'b0;
        spi_cs   = 3'd0;
        i2c_req  = 1'b0;
        i2c_busy = 1'b0;
        i2c_sel  = 3'd0;
        err_clr  = 1'b0;
    endtask

    // Reset and leave the arbiter in IDLE, just after a rising edge.
    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic go_idle();
        spi_req  = 1'b0;
        spi_busy = 1'b0;
        i2c_req  = 1'b0;
        i2c_busy = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        n_cmp++; if (ctrl !== 6'h00) begin n_err++; $display("FAIL rst_ctrl got %h want 00", ctrl); end
        n_cmp++; if (spi_gnt !== 1'b0) begin n_err++; $display("FAIL rst_spi_gnt got %b want 0", spi_gnt); end
        n_cmp++; if (i2c_gnt !== 1'b0) begin n_err++; $display("FAIL rst_i2c_gnt got %b want 0", i2c_gnt); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", timeout_err); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++; if (ctrl !== 6'h00) begin n_err++; $display("FAIL post_rst_first got %h want 00", ctrl); end
        tick();
        n_cmp++; if (ctrl !== 6'h20) begin n_err++; $display("FAIL post_rst_idle got %h want 20", ctrl); end
        tick();
        n_cmp++; if ({spi_gnt, i2c_gnt} !== 2'b00) begin n_err++; $display("FAIL idle_nogrant got %b want 00", {spi_gnt, i2c_gnt}); end
    endtask

    // Enters from IDLE and ends in GNT_SPI.
    task automatic test_spi_grant();
        spi_cs  = 3'b101;
        spi_pol = 1'b1;
        spi_req = 1'b1;
        tick();
        n_cmp++; if (ctrl !== 6'h3D) begin n_err++; $display("FAIL setup_ctrl got %h want 3d", ctrl); end
        n_cmp++; if (spi_gnt !== 1'b0) begin n_err++; $display("FAIL setup_nogrant got %b want 0", spi_gnt); end
        spi_cs  = 3'b010;
        spi_pol = 1'b0;
        repeat (3) tick();
        n_cmp++; if (spi_gnt !== 1'b0) begin n_err++; $display("FAIL guard_last got %b want 0", spi_gnt); end
        tick();
        n_cmp++; if (spi_gnt !== 1'b1) begin n_err++; $display("FAIL spi_gnt_rise got %b want 1", spi_gnt); end
        n_cmp++; if (ctrl !== 6'h3D) begin n_err++; $display("FAIL gnt_ctrl_hold got %h want 3d", ctrl); end
    endtask

    task automatic test_release();
        int bad;
        spi_busy = 1'b1;
        spi_req  = 1'b0;
        spi_cs   = 3'b000;
        tick();
        n_cmp++; if (spi_gnt !== 1'b1) begin n_err++; $display("FAIL busy_hold got %b want 1", spi_gnt); end
        spi_busy = 1'b0;
        tick();
        n_cmp++; if (spi_gnt !== 1'b0) begin n_err++; $display("FAIL rel_gnt got %b want 0", spi_gnt); end
        n_cmp++; if (ctrl !== 6'h20) begin n_err++; $display("FAIL rel_ctrl got %h want 20", ctrl); end
        // Request during RELEASE must wait until IDLE.
        i2c_sel = 3'b011;
        i2c_req = 1'b1;
        bad = 0;
        repeat (4) begin
            tick();
            if (ctrl !== 6'h20) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rel_guard_len got %0d bad cycles want 0", bad); end
        tick();
        n_cmp++; if (ctrl !== 6'h23) begin n_err++; $display("FAIL i2c_after_rel got %h want 23", ctrl); end
        go_idle();
    endtask

    task automatic test_round_robin();
        apply_reset();
        spi_cs  = 3'b001;
        spi_pol = 1'b0;
        i2c_sel = 3'b010;
        spi_req = 1'b1;
        i2c_req = 1'b1;
        tick();
        n_cmp++; if (ctrl !== 6'h31) begin n_err++; $display("FAIL rr1_ctrl got %h want 31", ctrl); end
        repeat (4) tick();
        n_cmp++; if ({spi_gnt, i2c_gnt} !== 2'b10) begin n_err++; $display("FAIL rr1_gnt got %b want 10", {spi_gnt, i2c_gnt}); end
        spi_req = 1'b0;
        tick();
        spi_req = 1'b1;
        repeat (9) tick();
        n_cmp++; if ({spi_gnt, i2c_gnt} !== 2'b01) begin n_err++; $display("FAIL rr2_gnt got %b want 01", {spi_gnt, i2c_gnt}); end
        n_cmp++; if (ctrl !== 6'h22) begin n_err++; $display("FAIL rr2_ctrl got %h want 22", ctrl); end
        i2c_req = 1'b0;
        tick();
        i2c_req = 1'b1;
        repeat (9) tick();
        n_cmp++; if ({spi_gnt, i2c_gnt} !== 2'b10) begin n_err++; $display("FAIL rr3_gnt got %b want 10", {spi_gnt, i2c_gnt}); end
        go_idle();
    endtask

    task automatic test_stb_drop();
        apply_reset();
        i2c_sel = 3'b101;
        i2c_req = 1'b1;
        repeat (5) tick();
        n_cmp++; if (i2c_gnt !== 1'b1) begin n_err++; $display("FAIL drop_pre_gnt got %b want 1", i2c_gnt); end
        n_cmp++; if (ctrl !== 6'h25) begin n_err++; $display("FAIL drop_pre_ctrl got %h want 25", ctrl); end
        stb_en = 1'b0;
        tick();
        n_cmp++; if ({spi_gnt, i2c_gnt} !== 2'b00) begin n_err++; $display("FAIL drop_gnt got %b want 00", {spi_gnt, i2c_gnt}); end
        n_cmp++; if (ctrl !== 6'h00) begin n_err++; $display("FAIL drop_ctrl got %h want 00", ctrl); end
        tick();
        n_cmp++; if (ctrl !== 6'h00) begin n_err++; $display("FAIL dtb_stay got %h want 00", ctrl); end
        stb_en = 1'b1;
        tick();
        n_cmp++; if (ctrl !== 6'h20) begin n_err++; $display("FAIL dtb_to_idle got %h want 20", ctrl); end
        tick();
        n_cmp++; if (ctrl !== 6'h25) begin n_err++; $display("FAIL regrant_setup got %h want 25", ctrl); end
        go_idle();
    endtask

    task automatic test_timeout();
        int drops;
        apply_reset();
        i2c_sel = 3'b110;
        i2c_req = 1'b1;
        repeat (5) tick();
        n_cmp++; if (i2c_gnt !== 1'b1) begin n_err++; $display("FAIL to_gnt1 got %b want 1", i2c_gnt); end
        repeat (15) tick();
        n_cmp++; if (i2c_gnt !== 1'b1) begin n_err++; $display("FAIL to_gnt16 got %b want 1", i2c_gnt); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_err_early got %b want 0", timeout_err); end
        tick();
`ifdef STB_ARB_TIMEOUT_EN
        n_cmp++; if (i2c_gnt !== 1'b0) begin n_err++; $display("FAIL to_forced_rel got %b want 0", i2c_gnt); end
        n_cmp++; if (ctrl !== 6'h20) begin n_err++; $display("FAIL to_rel_ctrl got %h want 20", ctrl); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_err_set got %b want 1", timeout_err); end
        tick();
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_err_sticky got %b want 1", timeout_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_err_clr got %b want 0", timeout_err); end
`else
        drops = (i2c_gnt !== 1'b1) ? 1 : 0;
        repeat (100) begin
            tick();
            if (i2c_gnt !== 1'b1) drops++;
        end
        n_cmp++; if (drops !== 0) begin n_err++; $display("FAIL hold_forever got %0d drops want 0", drops); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL no_wd_err got %b want 0", timeout_err); end
`endif
        go_idle();
    endtask

    initial begin
        test_reset();
        test_spi_grant();
        test_release();
        test_round_robin();
        test_stb_drop();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_time_limit reached without finishing");
        $fatal(1);
    end

endmodule

// File: doc/stb_port_arbiter.md
STB_PORT_ARBITER -- requirements
Module: stb_port_arbiter

Interface
REQ-001 Parameter GUARD, default 4, range 1..255: break-before-make guard length in clk cycles.
REQ-002 Parameter TIMEOUT, default 65535, range 1..65535: watchdog limit in clk cycles (used only with STB_ARB_TIMEOUT_EN).
REQ-003 Port clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 Port reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port stb_en  in  1  1 = STB mode enabled; 0 = DTB mode.
REQ-006 Port spi_req / spi_busy  in  1/1  SPI controller requests the shared port / has a transfer in progress.
REQ-007 Port spi_cs  in  3  SPI chip select; spi_pol  in  1  SCLK polarity.
REQ-008 Port i2c_req / i2c_busy  in  1/1  I2C controller request / transfer in progress.
REQ-009 Port i2c_sel  in  3  I2C address-line select.
REQ-010 Port spi_gnt / i2c_gnt  out  1/1  grant to the SPI / I2C controller.
REQ-011 Port ctrl  out  6  switch control word {mode_stb, mode_spi, spi_pol, sel[2:0]}; registered.
REQ-012 Port timeout_err  out  1  sticky watchdog flag; err_clr  in  1  clears the flag.

Function
REQ-013 States: DTB, IDLE, SETUP_SPI, SETUP_I2C, GNT_SPI, GNT_I2C, RELEASE; one state and one grant active at a time.
REQ-014 ctrl values: DTB = 6'h00; neutral (IDLE, RELEASE) = 6'h20; SPI phases = {1,1,pol_l,cs_l}; I2C phases = {1,0,0,sel_l}.
REQ-015 DTB->IDLE when stb_en=1 is sampled; in any state, stb_en=0 sampled -> DTB on the next cycle, both grants 0, ctrl=6'h00, counters cleared.
REQ-016 From IDLE, a sampled request -> SETUP_x on the next cycle, with ctrl switching to the target word in that same cycle; spi_cs/spi_pol or i2c_sel are latched into pol_l/cs_l/sel_l at that edge.
REQ-017 Tie in IDLE: round-robin. The last-granted requester loses. After reset the last-granted requester is I2C, so SPI wins the first tie.
REQ-018 SETUP_x lasts exactly GUARD cycles; gnt_x rises on the first GNT_x cycle. gnt_x therefore asserts GUARD+1 cycles after req is first sampled in IDLE.
REQ-019 In GNT_x, ctrl and the latched select/polarity remain constant; input changes to cs/pol/sel are ignored.
REQ-020 GNT_x -> RELEASE when req_x=0 and busy_x=0 are sampled together. In the next cycle gnt_x=0 and ctrl=6'h20.
REQ-021 RELEASE lasts exactly GUARD cycles, then -> IDLE; requests are not evaluated during SETUP or RELEASE.
REQ-022 A requester dropping req during SETUP_x still completes SETUP, is granted, and releases on the first cycle with req=busy=0.
REQ-023 Guard counter is 8 bits and never wraps: loaded with GUARD-1 on entry and decremented to 0.

Reset
REQ-024 While reset_n=0: state=DTB, spi_gnt=0, i2c_gnt=0, ctrl=6'h00, timeout_err=0, latched fields=0, last-granted=I2C, counters=0.
REQ-025 After reset_n deasserts, the first active edge evaluates stb_en per REQ-015.

Configuration
REQ-026 With macro STB_ARB_TIMEOUT_EN defined: a 16-bit watchdog counts GNT_x cycles. At count TIMEOUT, the block forces RELEASE as if req/busy had dropped and sets timeout_err=1.
REQ-027 timeout_err is cleared by err_clr=1; if a set and a clear occur in the same cycle, the set wins.
REQ-028 Without STB_ARB_TIMEOUT_EN: no watchdog logic is built, a grant is held indefinitely, timeout_err is tied to 0, and err_clr is ignored.

Verification
REQ-029 Reset with stb_en=1, then release: ctrl=6'h00 in the first cycle, 6'h20 from the second cycle; no grant.
REQ-030 GUARD=4, spi_req=1, spi_cs=3'b101, spi_pol=1: ctrl=6'h3D one cycle later, spi_gnt=1 five cycles after req is sampled.
REQ-031 Drop spi_req while spi_busy=1, then drop spi_busy: spi_gnt falls and ctrl=6'h20 the cycle after busy=0 is sampled; IDLE is reached 4 cycles later.
REQ-032 spi_req and i2c_req both held: the grant sequence is SPI, I2C, SPI.
REQ-033 stb_en drops during GNT_I2C: next cycle i2c_gnt=0 and ctrl=6'h00.
REQ-034 STB_ARB_TIMEOUT_EN with TIMEOUT=16 and i2c_req held: i2c_gnt falls after 16 grant cycles and timeout_err=1. A single err_clr pulse then clears it; without the macro, the grant is held for more than 100 cycles.
